// File: rtl/pulse_sync_ack.sv
// rtl/pulse_sync_ack.sv - handshaked cross-domain pulse transfer with acknowledge and event backlog
//
// Source domain (clk_s) turns single-cycle events into a request toggle and
// waits for the returned acknowledge toggle before sending the next one.
// Events that arrive while a transfer is in flight are queued in a counter
// and replayed one per acknowledge. The destination domain (clk_d)
// regenerates one single-cycle pulse per request toggle.
//
// Optional feature macro: PULSE_SYNC_ACK_DROP_CNT_EN (adds drop_cnt_s).
//
// Ports:
//   clk_s, rstn_s   source clock / asynchronous active-low reset
//   clk_d, rstn_d   destination clock / asynchronous active-low reset
//   event_s         single-cycle event in (clk_s)
//   busy_s          transfer in flight (clk_s)
//   ack_s           one-cycle pulse per delivered event (clk_s)
//   overflow_s      one-cycle pulse when an event is dropped at backlog saturation (clk_s)
//   pending_s       backlog count (clk_s)
//   drop_cnt_s      saturating count of dropped events (clk_s, optional)
//   event_d         regenerated single-cycle event (clk_d)

`timescale 1ns/1ps

module pulse_sync_ack #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk_s,
    input  logic             rstn_s,
    input  logic             clk_d,
    input  logic             rstn_d,
    input  logic             event_s,
    output logic             busy_s,
    output logic             ack_s,
    output logic             overflow_s,
    output logic [CNT_W-1:0] pending_s,
`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
    output logic [7:0]       drop_cnt_s,
`endif
    output logic             event_d
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Source domain
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_req_tgl;
    logic                   w_req_tgl_nxt;
    logic [CNT_W-1:0]       r_pending;
    logic [CNT_W-1:0]       w_pending_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_ack_dly;
    logic                   w_ack_edge;
    logic                   w_overflow;

    // Destination-domain toggles, declared here because they cross.
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_req_dly;

    assign w_ack_edge = r_ack_sync[SYNC_STAGES-1] ^ r_ack_dly;

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_state    <= ST_IDLE;
            r_req_tgl  <= 1'b0;
            r_pending  <= '0;
            r_ack_sync <= '0;
            r_ack_dly  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_tgl  <= w_req_tgl_nxt;
            r_pending  <= w_pending_nxt;
            // ack toggle comes straight from the destination r_req_dly flop
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_req_dly};
            r_ack_dly  <= r_ack_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_tgl_nxt = r_req_tgl;
        w_pending_nxt = r_pending;
        w_overflow    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (event_s) begin
                    w_req_tgl_nxt = ~r_req_tgl;
                    w_state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ack_edge) begin
                    if (r_pending != '0) begin
                        // replay one queued event; a simultaneous new event
                        // takes its place in the backlog
                        w_req_tgl_nxt = ~r_req_tgl;
                        if (!event_s) begin
                            w_pending_nxt = r_pending - PEND_ONE;
                        end
                    end else if (event_s) begin
                        w_req_tgl_nxt = ~r_req_tgl;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (event_s) begin
                    if (r_pending != PEND_MAX) begin
                        w_pending_nxt = r_pending + PEND_ONE;
                    end else begin
                        w_overflow = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy_s     = (r_state == ST_WAIT);
    assign ack_s      = w_ack_edge;
    assign overflow_s = w_overflow;
    assign pending_s  = r_pending;

`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_drop_cnt <= 8'd0;
        end else if (w_overflow && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_s = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // Destination domain
    // ------------------------------------------------------------------
    always_ff @(posedge clk_d or negedge rstn_d) begin
        if (!rstn_d) begin
            r_req_sync <= '0;
            r_req_dly  <= 1'b0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
            r_req_dly  <= r_req_sync[SYNC_STAGES-1];
        end
    end

    // r_req_dly doubles as the acknowledge toggle, so the ack flips one
    // clk_d edge after event_d rises.
    assign event_d = r_req_sync[SYNC_STAGES-1] ^ r_req_dly;

endmodule

// File: tb/tb_pulse_sync_ack.sv
// tb/tb_pulse_sync_ack.sv - directed self-checking bench for pulse_sync_ack

`timescale 1ns/1ps

module tb_pulse_sync_ack;

    logic clk_s  = 1'b0;
    logic clk_da = 1'b0;
    logic clk_db = 1'b0;
    logic rstn   = 1'b0;
    logic event_a = 1'b0;
    logic event_b = 1'b0;
    realtime half_b = 10.0;

    logic       busy_a, ack_a, ovf_a, evd_a;
    logic [2:0] pend_a;
    logic       busy_b, ack_b, ovf_b, evd_b;
    logic [1:0] pend_b;
`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
    logic [7:0] drop_a, drop_b;
`endif

    int total = 0;
    int bad   = 0;
    int n_evd_a = 0, n_ack_a = 0, n_ovf_a = 0, peak_a = 0;
    int n_evd_b = 0, n_ack_b = 0, n_ovf_b = 0, n_wide_b = 0;
    logic prev_b = 1'b0;
    int e0, a0, o0, w0;

    always #5 clk_s = ~clk_s;
    always #10 clk_da = ~clk_da;
    always begin
        #(half_b);
        clk_db = ~clk_db;
    end

    pulse_sync_ack #(.SYNC_STAGES(2), .CNT_W(3)) u_a (
        .clk_s(clk_s), .rstn_s(rstn), .clk_d(clk_da), .rstn_d(rstn),
        .event_s(event_a), .busy_s(busy_a), .ack_s(ack_a),
        .overflow_s(ovf_a), .pending_s(pend_a),
`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
        .drop_cnt_s(drop_a),
`endif
        .event_d(evd_a)
    );

    pulse_sync_ack #(.SYNC_STAGES(3), .CNT_W(2)) u_b (
        .clk_s(clk_s), .rstn_s(rstn), .clk_d(clk_db), .rstn_d(rstn),
        .event_s(event_b), .busy_s(busy_b), .ack_s(ack_b),
        .overflow_s(ovf_b), .pending_s(pend_b),
`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
        .drop_cnt_s(drop_b),
`endif
        .event_d(evd_b)
    );

    always @(negedge clk_da) begin
        if (evd_a) n_evd_a++;
    end

    always @(negedge clk_db) begin
        if (evd_b) begin
            n_evd_b++;
            if (prev_b) n_wide_b++;
        end
        prev_b = evd_b;
    end

    always @(negedge clk_s) begin
        if (ack_a) n_ack_a++;
        if (ovf_a) n_ovf_a++;
        if (ack_b) n_ack_b++;
        if (ovf_b) n_ovf_b++;
        if (int'(pend_a) > peak_a) peak_a = int'(pend_a);
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic burst_a(input int n);
        @(posedge clk_s); #1 event_a = 1'b1;
        repeat (n) @(posedge clk_s);
        #1 event_a = 1'b0;
    endtask

    task automatic burst_b(input int n);
        @(posedge clk_s); #1 event_b = 1'b1;
        repeat (n) @(posedge clk_s);
        #1 event_b = 1'b0;
    endtask

    task automatic wait_ack_a(input string tag);
        int k = 0;
        while (!ack_a && k < 200) begin
            @(negedge clk_s);
            k++;
        end
        check(tag, int'(ack_a), 1);
    endtask

    task automatic wait_idle_a(input string tag);
        int k = 0;
        while (busy_a && k < 500) begin
            @(negedge clk_s);
            k++;
        end
        check(tag, int'(busy_a), 0);
    endtask

    task automatic wait_idle_b(input string tag);
        int k = 0;
        while (busy_b && k < 1000) begin
            @(negedge clk_s);
            k++;
        end
        check(tag, int'(busy_b), 0);
    endtask

    initial begin
        // reset state
        #23;
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_ack_a",  int'(ack_a),  0);
        check("rst_ovf_a",  int'(ovf_a),  0);
        check("rst_pend_a", int'(pend_a), 0);
        check("rst_evd_a",  int'(evd_a),  0);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_pend_b", int'(pend_b), 0);
        @(negedge clk_s);
        rstn = 1'b1;
        repeat (3) @(posedge clk_s);

        // single event
        e0 = n_evd_a; a0 = n_ack_a;
        burst_a(1);
        check("t1_busy_rise", int'(busy_a), 1);
        check("t1_pend",      int'(pend_a), 0);
        wait_ack_a("t1_ack_seen");
        check("t1_busy_at_ack", int'(busy_a), 1);
        @(posedge clk_s); #1;
        check("t1_busy_fall", int'(busy_a), 0);
        check("t1_evd_cnt",   n_evd_a - e0, 1);
        check("t1_ack_cnt",   n_ack_a - a0, 1);
        check("t1_peak",      peak_a, 0);

        // three events 20ns apart
        e0 = n_evd_a; a0 = n_ack_a;
        burst_a(1);
        burst_a(1);
        burst_a(1);
        check("t2_pend_after3", int'(pend_a), 2);
        wait_idle_a("t2_idle");
        check("t2_peak",    peak_a, 2);
        check("t2_evd_cnt", n_evd_a - e0, 3);
        check("t2_ack_cnt", n_ack_a - a0, 3);
        check("t2_pend_end", int'(pend_a), 0);

        // event coincident with ack edge at pending 1
        e0 = n_evd_a; a0 = n_ack_a; o0 = n_ovf_a;
        burst_a(2);
        check("t3_pend_pre", int'(pend_a), 1);
        wait_ack_a("t3_ack_seen");
        event_a = 1'b1;
        @(posedge clk_s); #1 event_a = 1'b0;
        check("t3_pend_hold", int'(pend_a), 1);
        check("t3_busy",      int'(busy_a), 1);
        wait_idle_a("t3_idle");
        check("t3_evd_cnt", n_evd_a - e0, 3);
        check("t3_ack_cnt", n_ack_a - a0, 3);
        check("t3_ovf_cnt", n_ovf_a - o0, 0);

        // reset while busy with backlog 2
        burst_a(3);
        check("t4_pend_pre", int'(pend_a), 2);
        #2 rstn = 1'b0;
        #1;
        check("t4_busy_rst", int'(busy_a), 0);
        check("t4_pend_rst", int'(pend_a), 0);
        check("t4_ack_rst",  int'(ack_a),  0);
        check("t4_evd_rst",  int'(evd_a),  0);
        #30 rstn = 1'b1;
        e0 = n_evd_a; a0 = n_ack_a;
        repeat (20) @(posedge clk_s);
        #1;
        check("t4_quiet_evd", n_evd_a - e0, 0);
        check("t4_quiet_ack", n_ack_a - a0, 0);
        burst_a(1);
        wait_ack_a("t4_new_ack");
        wait_idle_a("t4_idle");
        check("t4_new_evd", n_evd_a - e0, 1);
        check("t4_new_ackc", n_ack_a - a0, 1);

        // saturation on the CNT_W=2 instance
        e0 = n_evd_b; a0 = n_ack_b; o0 = n_ovf_b;
        burst_b(6);
        check("t5_pend_sat", int'(pend_b), 3);
        check("t5_busy",     int'(busy_b), 1);
        check("t5_ovf_cnt",  n_ovf_b - o0, 2);
`ifdef PULSE_SYNC_ACK_DROP_CNT_EN
        check("t5_drop_cnt", int'(drop_b), 2);
`endif
        wait_idle_b("t5_idle");
        check("t5_evd_cnt", n_evd_b - e0, 4);
        check("t5_ack_cnt", n_ack_b - a0, 4);
        check("t5_ovf_end", n_ovf_b - o0, 2);

        // fast destination clock, randomly spaced events
        half_b = 3.5;
        repeat (5) @(posedge clk_s);
        e0 = n_evd_b; a0 = n_ack_b; o0 = n_ovf_b; w0 = n_wide_b;
        for (int i = 0; i < 10; i++) begin
            burst_b(1);
            repeat ($urandom_range(5, 12)) @(posedge clk_s);
        end
        wait_idle_b("t6_idle");
        check("t6_evd_cnt",  n_evd_b - e0, 10);
        check("t6_ack_cnt",  n_ack_b - a0, 10);
        check("t6_wide",     n_wide_b - w0, 0);
        check("t6_ovf_cnt",  n_ovf_b - o0, 0);
        check("t6_pend_end", int'(pend_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_sync_ack.md
Name: pulse_sync_ack

Overview:
- Handshaked cross-domain pulse transfer with a return acknowledge path.
- Source domain (clk_s) converts single-cycle events into a request toggle. Destination domain (clk_d) regenerates a single-cycle pulse and returns an acknowledge toggle. The source sees a done pulse and a busy flag.
- Events arriving while a transfer is in flight are counted and replayed, so closely spaced pulses are not merged or lost up to the counter depth.
- Sits beside the plain toggle pulse synchronizer, for control events that need delivery confirmation or that may burst faster than clk_d.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops in each crossing direction (legal 2..4).
- CNT_W, 3, width of the source-side pending-event counter; max backlog 2^CNT_W-1.

Ports:
- clk_s  input  1  source clock.
- rstn_s  input  1  source reset, asynchronous, active-low.
- clk_d  input  1  destination clock.
- rstn_d  input  1  destination reset, asynchronous, active-low.
- event_s  input  1  single-cycle event in clk_s domain.
- busy_s  output  1  transfer in flight (clk_s).
- ack_s  output  1  one-cycle pulse per delivered event (clk_s).
- overflow_s  output  1  one-cycle pulse when an event is dropped because the pending counter is saturated (clk_s).
- pending_s  output  CNT_W  current backlog count (clk_s).
- event_d  output  1  one-cycle regenerated event (clk_d).

Behaviour:
- Reset: all flops 0. busy_s=0, ack_s=0, overflow_s=0, pending_s=0, event_d=0.
- Source FSM, two states:
  - IDLE: on event_s=1, flip req_tgl at that edge, go to WAIT, busy_s=1 from the next cycle.
  - WAIT: busy_s=1.
- ack_edge = ack_sync XOR ack_dly, where ack_sync is ack_tgl through SYNC_STAGES clk_s flops and ack_dly is one more flop. ack_s = ack_edge (combinational from flops, one cycle).
- WAIT handling, by case:
  - event_s=1 and no ack_edge: pending_s+1 if < 2^CNT_W-1. Otherwise pending_s holds and overflow_s=1 for that cycle.
  - ack_edge and pending_s>0: flip req_tgl, pending_s-1, stay in WAIT.
  - ack_edge, pending_s>0 and event_s together: flip req_tgl, pending_s unchanged.
  - ack_edge, pending_s=0 and event_s=1: flip req_tgl, stay in WAIT (new event served directly).
  - ack_edge, pending_s=0 and event_s=0: go to IDLE.
- Destination side:
  - req_tgl passes through SYNC_STAGES clk_d flops to give req_sync, plus req_dly.
  - event_d = req_sync XOR req_dly.
  - ack_tgl = req_dly, so it toggles one clk_d edge after event_d asserts.
- Latency:
  - event_s sampled at clk_s edge N; req_tgl flips at N.
  - event_d is high between clk_d edges SYNC_STAGES and SYNC_STAGES+1 after the flip (plus up to one clk_d period of phase uncertainty).
  - ack_s asserts SYNC_STAGES clk_s edges after the ack_tgl flip is first sampled.
- Exactly one event_d per accepted event_s. Events dropped at saturation never produce event_d or ack_s.
- Only req_tgl and ack_tgl cross domains. Each is driven directly from a flop, with no combinational logic before the synchronizers.
- Reset mid-operation:
  - rstn_s and rstn_d must be asserted overlapping (system rule).
  - On reset, the backlog is discarded and busy_s returns to 0 asynchronously.
  - After both deassert, toggles are equal and no spurious event_d or ack_s occurs.

Optional Feature:
- Macro: PULSE_SYNC_ACK_DROP_CNT_EN.
- Defined: adds output drop_cnt_s [7:0] (clk_s). It increments on every overflow_s pulse, saturates at 255, and clears only on rstn_s.
- Undefined: port and counter absent; overflow_s behaviour is unchanged.

Test Plan:
- clk_s 10ns, clk_d 20ns, single event_s after reset -> exactly one event_d pulse (20ns wide), one ack_s. busy_s high from event+1 until the ack_s cycle, pending_s stays 0.
- Three event_s pulses 20ns apart -> pending_s peaks at 2, three event_d pulses, three ack_s in order, busy_s falls after the third ack_s.
- CNT_W=2, 6 back-to-back event_s -> first accepted, pending reaches 3, two overflow_s pulses, exactly 4 event_d and 4 ack_s. With PULSE_SYNC_ACK_DROP_CNT_EN, drop_cnt_s=2.
- event_s coincident with ack_edge at pending_s=1 -> pending_s stays 1, req_tgl flips, total event_d count matches accepted events.
- Both resets asserted while busy_s=1 with pending_s=2 -> outputs 0 immediately. After release, no event_d or ack_s for 20 clk_s cycles, and a new event_s is delivered normally.
- clk_d 7ns (faster than clk_s), SYNC_STAGES=3, 10 random-spaced events -> event_d count equals 10 and every event_d is exactly one clk_d cycle wide.
